// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts DATA_W-bit words over valid/ready and feeds them
// MSB-first through a PAT_W-bit history window. Each new bit is checked
// against a programmable pattern, with overlapping matches allowed. Each hit
// is reported with the index of the bit that completed it. Hits are also
// tallied in a saturating counter.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a word; in_ready_o high
// SHIFT | consuming one bit per clock, MSB first, bit index counts down
// DONE  | single cycle with done_o high, then back to IDLE
module pattern_scan_ctrl #(
   parameter int PAT_W  = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      clr_i,
   input  logic [PAT_W-1:0]          pattern_i,
   input  logic                      in_valid_i,
   input  logic [DATA_W-1:0]         in_data_i,
   output logic                      in_ready_o,
   output logic                      busy_o,
   output logic                      hit_o,
   output logic [$clog2(DATA_W)-1:0] hit_pos_o,
   output logic                      done_o,
   output logic [CNT_W-1:0]          match_cnt_o,
   output logic                      cnt_sat_o
);

   localparam int IDX_W  = $clog2(DATA_W);
   localparam int SEEN_W = $clog2(PAT_W + 1);
   localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [PAT_W-1:0]    pat_q, pat_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PAT_W-1:0]    hist_q, hist_d;
   logic [SEEN_W-1:0]   seen_q, seen_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                hit_q, hit_d;
   logic [IDX_W-1:0]    pos_q, pos_d;
   logic                done_q, done_d;

   // State and datapath registers; history/seen persist across words so
   // matches can straddle a word boundary.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         shreg_q <= '0;
         pat_q   <= '0;
         idx_q   <= '0;
         hist_q  <= '0;
         seen_q  <= '0;
         cnt_q   <= '0;
         hit_q   <= 1'b0;
         pos_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         pat_q   <= pat_d;
         idx_q   <= idx_d;
         hist_q  <= hist_d;
         seen_q  <= seen_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
         pos_q   <= pos_d;
         done_q  <= done_d;
      end
   end

   // Next-state, bit shifting, hit detection and match counting; clr wins
   // over the match logic but leaves the word in progress untouched.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
      hist_d  = hist_q;
      seen_d  = seen_q;
      cnt_d   = cnt_q;
      hit_d   = 1'b0;
      pos_d   = pos_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               shreg_d = in_data_i;
               pat_d   = pattern_i;
               idx_d   = IDX_LAST;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d = shreg_q << 1;
            hist_d  = {hist_q[PAT_W-2:0], shreg_q[DATA_W-1]};
            seen_d  = (seen_q == SEEN_MAX) ? seen_q : seen_q + 1'b1;
            if ((seen_d == SEEN_MAX) && (hist_d == pat_q)) begin
               hit_d = 1'b1;
               pos_d = idx_q;
            end
            if (idx_q == '0) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (hit_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (clr_i) begin
         hist_d = '0;
         seen_d = '0;
         cnt_d  = '0;
         hit_d  = 1'b0;
         pos_d  = pos_q;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign busy_o      = (state_q == SHIFT) || (state_q == DONE);
   assign hit_o       = hit_q;
   assign hit_pos_o   = pos_q;
   assign done_o      = done_q;
   assign match_cnt_o = cnt_q;
   assign cnt_sat_o   = &cnt_q;

endmodule
